dmem_rv32: RTL and testbench
============================

# dmem_rv32

Data-memory responder for the RV32I pipeline. It services the load/store requests issued by the Memory Access stage and holds that stage with `oStallD` while an access is in flight. It performs byte, halfword and word accesses on a word-organised RAM, and returns load data already lane-aligned and sign- or zero-extended. A parameterised wait-state counter models DCache/RAM latency, so the MA-stage stall path is exercised for real.

## Interface
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; must be a power of two.
- `LATENCY`, default 2: wait-state cycles per access; must be 1 or more.
- `iCLK`, input, 1: clock; all state changes on the rising edge.
- `iRSTn`, input, 1: reset; one clock, reset is asynchronous and active-low.
- `iMEM`, input, 1: request valid; a memory transaction is to be performed.
- `iRW`, input, 1: 1 = read (load), 0 = write (store).
- `iADDR`, input, 32: byte address.
- `iWDATA`, input, 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `iSIZE`, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `iUNSIGNED`, input, 1: 1 = zero-extend load data (LBU/LHU), 0 = sign-extend.
- `oStallD`, output, 1: combinational; 1 = MA stage must hold its request and not advance.
- `oRDATA`, output, 32: registered load result.
- `oValid`, output, 1: registered; 1 for exactly one cycle when the access completes.
- `oMisalign`, output, 1: combinational; request rejected as misaligned or illegal.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - BUSY: wait-state down-counter `cnt` running; width is clog2 of `LATENCY`, minimum 1 bit.
  - RESP: one cycle in which the response is presented.
- Misaligned request:
  - Conditions: `iSIZE`=01 with `iADDR[0]`=1; `iSIZE`=10 with `iADDR[1:0]`≠0; or `iSIZE`=11.
  - Response: `oMisalign`=1 and `oStallD`=0 while in IDLE. No state change, no RAM write, `oValid` stays 0.
- IDLE, when `iMEM`=1 and the request is aligned:
  - Assert `oStallD`.
  - Latch `iRW`, word index, byte lane `iADDR[1:0]`, `iSIZE`, `iUNSIGNED` and `iWDATA`.
  - Load `cnt` with `LATENCY-1` and go to BUSY.
- Word index is `iADDR[clog2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo 4·`DEPTH_WORDS` bytes.
- BUSY:
  - `oStallD`=1.
  - If `cnt`≠0, decrement.
  - If `cnt`=0, perform the access on this edge and go to RESP.
- Write (access edge):
  - Byte enables: byte → 1 lane at `lane`; half → lanes {`lane`+1, `lane`}; word → all 4.
  - Data is replicated into the enabled lanes; other bytes are unchanged.
  - `oRDATA` is unchanged.
- Read (access edge):
  - Select the byte or half at `lane` from the stored word.
  - Extend to 32 bits per the latched `iUNSIGNED`; a word is passed through.
  - Register the result into `oRDATA`.
- RESP:
  - `oStallD`=0 and `oValid`=1.
  - `iMEM` is ignored in this cycle, because it still belongs to the completing instruction.
  - Go to IDLE next edge.
- `oRDATA` holds its value until the next completing read.
- The RAM is not reset. Contents are undefined until written.

## Timing
- Aligned access, request first seen in IDLE at cycle 0:
  - `oStallD`=1 in cycles 0..`LATENCY`.
  - RESP occurs in cycle `LATENCY`+1, with `oValid`=1 and `oRDATA` valid.
  - Total is `LATENCY`+2 cycles including the response cycle. A back-to-back request is recognised in cycle `LATENCY`+2.
- A store's RAM update is visible to a read that starts in the RESP cycle or later.
- `oStallD` and `oMisalign` are combinational from `iMEM`, `iADDR`, `iSIZE` and the state; there is no registered delay.
- Reset (`iRSTn`=0, asynchronous):
  - State → IDLE, `cnt`=0, `oRDATA`=0, `oValid`=0.
  - `oStallD` and `oMisalign` are forced to 0 while reset is asserted.
- Reset asserted in BUSY before the access edge aborts the access; no RAM write occurs.
- The first cycle after reset deassertion is IDLE and accepts a request.
- Requester rule: `iMEM`, `iRW`, `iADDR`, `iSIZE`, `iUNSIGNED` and `iWDATA` must stay stable while `oStallD`=1. The block relies only on the values latched in IDLE.

## Test plan
- **Word store then load:** with `LATENCY`=2, SW 0xDEADBEEF to 0x10, then LW 0x10.
  - Stall is asserted for 3 cycles per access.
  - `oValid` pulses in the 4th cycle of each access.
  - `oRDATA`=0xDEADBEEF.
- **Byte load extension:** after SW 0x80FF7F01 to 0x20:
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - LB 0x21 → 0x0000007F; LH 0x22 → 0xFFFF80FF.
- **Partial stores:** SW 0 to 0x30, SB 0xAB to 0x31, SH 0x1234 to 0x32, then LW 0x30 → 0x1234AB00.
- **Misalignment:** LH 0x41, LW 0x42 and `iSIZE`=11 each give `oMisalign`=1 and `oStallD`=0, with no state change.
  - A following LW 0x40 returns the old contents, proving the rejected requests wrote nothing.
- **Reset mid-access:** start SW 0x55555555 to 0x50 (old value 0x11111111) and pulse `iRSTn` low in the first BUSY cycle.
  - During reset: `oStallD`=0, `oValid`=0, `oRDATA`=0.
  - A subsequent LW 0x50 → 0x11111111.
- **Wrap and back-to-back:** with `DEPTH_WORDS`=1024, SW 0xCAFEF00D to 0x1000 then LW 0x0 in the next IDLE cycle.
  - Read returns 0xCAFEF00D.
  - Repeat the sequence with `LATENCY`=1 and check the stall is 2 cycles per access.

Source files
------------

// File: rtl/dmem_rv32_if.sv
// dmem_rv32 bus: MA-stage request and data-memory response.
// master = MA stage requester, slave = dmem_rv32 responder.
interface dmem_rv32_if;
   logic        iMEM;
   logic        iRW;
   logic [31:0] iADDR;
   logic [31:0] iWDATA;
   logic [1:0]  iSIZE;
   logic        iUNSIGNED;
   logic        oStallD;
   logic [31:0] oRDATA;
   logic        oValid;
   logic        oMisalign;

   modport master (
      output iMEM, iRW, iADDR, iWDATA, iSIZE, iUNSIGNED,
      input  oStallD, oRDATA, oValid, oMisalign
   );

   modport slave (
      input  iMEM, iRW, iADDR, iWDATA, iSIZE, iUNSIGNED,
      output oStallD, oRDATA, oValid, oMisalign
   );
endinterface

// File: rtl/dmem_rv32.sv
// RV32I data memory with byte/half/word access and LATENCY wait states.
// Ports: iCLK, iRSTn (async, active-low), bus (dmem_rv32_if.slave).
module dmem_rv32 #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic       iCLK,
   input logic       iRSTn,
   dmem_rv32_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic          rwQ, unsQ, validQ;
   logic [AW-1:0] idxQ;
   logic [1:0]    laneQ, sizeQ;
   logic [31:0]   wdataQ, rdataQ;
   logic [31:0]   ram [DEPTH_WORDS];

   logic        bad, accept, access, stall, mis;
   logic [31:0] word, ldData, wRep;
   logic [7:0]  bSel;
   logic [15:0] hSel;
   logic [3:0]  be;
   logic        unusedOk;

   // Upper address bits wrap by design.
   assign unusedOk = ^bus.iADDR[31:AW+2];

   always_comb begin
      bad = 1'b0;
      case (bus.iSIZE)
         2'b00:   bad = 1'b0;
         2'b01:   bad = bus.iADDR[0];
         2'b10:   bad = |bus.iADDR[1:0];
         default: bad = 1'b1;
      endcase
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      accept    = 1'b0;
      access    = 1'b0;
      stall     = 1'b0;
      mis       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iMEM) begin
               if (bad) begin
                  mis = 1'b1;
               end else begin
                  accept    = 1'b1;
                  stall     = 1'b1;
                  cntNext   = CW'(LATENCY - 1);
                  stateNext = BUSY;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt != '0) begin
               cntNext = cnt - CW'(1);
            end else begin
               access    = 1'b1;
               stateNext = RESP;
            end
         end
         // iMEM here still belongs to the completing access.
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign bus.oStallD   = stall & iRSTn;
   assign bus.oMisalign = mis & iRSTn;
   assign bus.oRDATA    = rdataQ;
   assign bus.oValid    = validQ;

   // Load path: pick lane, then extend.
   assign word = ram[idxQ];
   assign bSel = word[8*laneQ +: 8];
   assign hSel = laneQ[1] ? word[31:16] : word[15:0];

   always_comb begin
      ldData = word;
      case (sizeQ)
         2'b00:   ldData = {{24{~unsQ & bSel[7]}}, bSel};
         2'b01:   ldData = {{16{~unsQ & hSel[15]}}, hSel};
         default: ldData = word;
      endcase
   end

   // Store path: replicate data, enable only the addressed lanes.
   always_comb begin
      be   = 4'b1111;
      wRep = wdataQ;
      case (sizeQ)
         2'b00: begin
            be   = 4'b0001 << laneQ;
            wRep = {4{wdataQ[7:0]}};
         end
         2'b01: begin
            be   = laneQ[1] ? 4'b1100 : 4'b0011;
            wRep = {2{wdataQ[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            wRep = wdataQ;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state  <= IDLE;
         cnt    <= '0;
         rwQ    <= 1'b0;
         unsQ   <= 1'b0;
         idxQ   <= '0;
         laneQ  <= 2'b00;
         sizeQ  <= 2'b00;
         wdataQ <= '0;
         rdataQ <= '0;
         validQ <= 1'b0;
      end else begin
         state  <= stateNext;
         cnt    <= cntNext;
         validQ <= access;
         if (accept) begin
            rwQ    <= bus.iRW;
            unsQ   <= bus.iUNSIGNED;
            idxQ   <= bus.iADDR[AW+1:2];
            laneQ  <= bus.iADDR[1:0];
            sizeQ  <= bus.iSIZE;
            wdataQ <= bus.iWDATA;
         end
         if (access && rwQ) rdataQ <= ldData;
      end
   end

   // RAM has no reset; access is already squashed by reset via state.
   always_ff @(posedge iCLK) begin
      if (access && !rwQ) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) ram[idxQ][8*i +: 8] <= wRep[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_rv32.sv
// Bench for dmem_rv32: directed plan plus random loads/stores vs byte model.
// Two DUTs: u2 (LATENCY=2) and u1 (LATENCY=1), selected by sel.
module tb_dmem_rv32;
   logic        clk = 1'b0;
   logic        rstN;
   logic        sel;
   logic        mem, rw, uns;
   logic [31:0] addr, wdata;
   logic [1:0]  size;

   int nCmp = 0;
   int nBad = 0;

   logic [7:0]  refm [2][4096];
   logic [31:0] lastRd [2];

   dmem_rv32_if i2 ();
   dmem_rv32_if i1 ();

   assign i2.iMEM      = mem & ~sel;
   assign i1.iMEM      = mem & sel;
   assign i2.iRW       = rw;
   assign i1.iRW       = rw;
   assign i2.iADDR     = addr;
   assign i1.iADDR     = addr;
   assign i2.iWDATA    = wdata;
   assign i1.iWDATA    = wdata;
   assign i2.iSIZE     = size;
   assign i1.iSIZE     = size;
   assign i2.iUNSIGNED = uns;
   assign i1.iUNSIGNED = uns;

   dmem_rv32 #(.DEPTH_WORDS(1024), .LATENCY(2)) u2 (
      .iCLK(clk), .iRSTn(rstN), .bus(i2)
   );
   dmem_rv32 #(.DEPTH_WORDS(1024), .LATENCY(1)) u1 (
      .iCLK(clk), .iRSTn(rstN), .bus(i1)
   );

   wire        stallO = sel ? i1.oStallD : i2.oStallD;
   wire        validO = sel ? i1.oValid : i2.oValid;
   wire        misO   = sel ? i1.oMisalign : i2.oMisalign;
   wire [31:0] rdO    = sel ? i1.oRDATA : i2.oRDATA;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nBad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] refLoad(input bit s, input logic [31:0] a,
                                           input logic [1:0] sz, input bit u);
      int n;
      logic [31:0] v;
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      v = '0;
      for (int i = 0; i < n; i++)
         v = v | (32'(refm[s][(a + i) & 32'hFFF]) << (8 * i));
      if (!u && n < 4 && v[8*n-1])
         v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   // Called just after a rising edge in an IDLE cycle; returns after the
   // rising edge that ends the response cycle.
   task automatic doAcc(input bit s, input bit r, input logic [31:0] a,
                        input logic [31:0] w, input logic [1:0] sz,
                        input bit u, output logic [31:0] rd,
                        output int stalls, output int vcyc);
      sel = s; mem = 1'b1; rw = r; addr = a; wdata = w; size = sz; uns = u;
      stalls = 0;
      vcyc = -1;
      rd = 'x;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (stallO) stalls++;
         if (validO && vcyc < 0) begin
            vcyc = c;
            rd = rdO;
         end
         @(posedge clk);
         #1;
         if (vcyc >= 0) break;
      end
      mem = 1'b0;
   endtask

   task automatic st(input bit s, input logic [31:0] a, input logic [31:0] w,
                     input logic [1:0] sz, input string tag);
      logic [31:0] rd;
      int stl, vc, n;
      doAcc(s, 1'b0, a, w, sz, 1'b0, rd, stl, vc);
      chk({tag, "_stall"}, stl, s ? 2 : 3);
      chk({tag, "_vcyc"}, vc, s ? 2 : 3);
      chk({tag, "_rdhold"}, rd, lastRd[s]);
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++)
         refm[s][(a + i) & 32'hFFF] = w[8*i +: 8];
   endtask

   task automatic ld(input bit s, input logic [31:0] a, input logic [1:0] sz,
                     input bit u, input string tag, input logic [31:0] exp);
      logic [31:0] rd;
      int stl, vc;
      doAcc(s, 1'b1, a, 32'h0, sz, u, rd, stl, vc);
      chk({tag, "_stall"}, stl, s ? 2 : 3);
      chk({tag, "_vcyc"}, vc, s ? 2 : 3);
      chk({tag, "_data"}, rd, exp);
      lastRd[s] = exp;
   endtask

   task automatic mis(input bit s, input bit r, input logic [31:0] a,
                      input logic [1:0] sz, input string tag);
      sel = s; mem = 1'b1; rw = r; addr = a; wdata = $urandom; size = sz;
      uns = 1'b0;
      @(negedge clk);
      chk({tag, "_mis"}, misO, 1'b1);
      chk({tag, "_stall"}, stallO, 1'b0);
      @(posedge clk);
      #1;
      mem = 1'b0;
      @(negedge clk);
      chk({tag, "_valid"}, validO, 1'b0);
      chk({tag, "_stall2"}, stallO, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      bit          badA;

      lastRd[0] = '0;
      lastRd[1] = '0;
      rstN = 1'b0; sel = 1'b0; mem = 1'b1; rw = 1'b1;
      addr = 32'h3; wdata = '0; size = 2'b11; uns = 1'b0;
      #2;
      chk("rst_stall", stallO, 1'b0);
      chk("rst_mis", misO, 1'b0);
      chk("rst_valid", validO, 1'b0);
      chk("rst_rdata", rdO, 32'h0);
      mem = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      // Word store then load
      st(0, 32'h10, 32'hDEADBEEF, 2'b10, "sw10");
      ld(0, 32'h10, 2'b10, 0, "lw10", 32'hDEADBEEF);

      // Byte/half load extension
      st(0, 32'h20, 32'h80FF7F01, 2'b10, "sw20");
      ld(0, 32'h23, 2'b00, 0, "lb23", 32'hFFFFFF80);
      ld(0, 32'h23, 2'b00, 1, "lbu23", 32'h00000080);
      ld(0, 32'h21, 2'b00, 0, "lb21", 32'h0000007F);
      ld(0, 32'h22, 2'b01, 0, "lh22", 32'hFFFF80FF);

      // Partial stores
      st(0, 32'h30, 32'h0, 2'b10, "sw30");
      st(0, 32'h31, 32'hAB, 2'b00, "sb31");
      st(0, 32'h32, 32'h1234, 2'b01, "sh32");
      ld(0, 32'h30, 2'b10, 0, "lw30", 32'h1234AB00);

      // Misalignment leaves memory untouched
      st(0, 32'h40, 32'h76543210, 2'b10, "sw40");
      mis(0, 1'b1, 32'h41, 2'b01, "lh41");
      mis(0, 1'b1, 32'h42, 2'b10, "lw42");
      mis(0, 1'b0, 32'h40, 2'b11, "sz11");
      mis(0, 1'b0, 32'h43, 2'b01, "sh43");
      mis(0, 1'b0, 32'h41, 2'b10, "sw41");
      ld(0, 32'h40, 2'b10, 0, "lw40", 32'h76543210);

      // Reset in the first BUSY cycle aborts the store
      st(0, 32'h50, 32'h11111111, 2'b10, "sw50");
      ld(0, 32'h50, 2'b10, 0, "lw50a", 32'h11111111);
      sel = 1'b0; mem = 1'b1; rw = 1'b0; addr = 32'h50;
      wdata = 32'h55555555; size = 2'b10; uns = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_stall", stallO, 1'b1);
      rstN = 1'b0;
      mem = 1'b0;
      #1;
      chk("mrst_stall", stallO, 1'b0);
      chk("mrst_valid", validO, 1'b0);
      chk("mrst_rdata", rdO, 32'h0);
      #2;
      rstN = 1'b1;
      lastRd[0] = '0;
      lastRd[1] = '0;
      @(posedge clk);
      #1;
      ld(0, 32'h50, 2'b10, 0, "lw50b", 32'h11111111);

      // Address wrap with back-to-back access, both latencies
      st(0, 32'h1000, 32'hCAFEF00D, 2'b10, "sw1000");
      ld(0, 32'h0, 2'b10, 0, "lw0", 32'hCAFEF00D);
      st(1, 32'h1000, 32'hCAFEF00D, 2'b10, "l1_sw1000");
      ld(1, 32'h0, 2'b10, 0, "l1_lw0", 32'hCAFEF00D);

      // Random traffic on a 256-byte window against the byte model
      for (int i = 0; i < 64; i++)
         st(0, 32'h200 + 32'(4 * i), $urandom, 2'b10, "init");
      for (int i = 0; i < 80; i++) begin
         sz = 2'($urandom_range(3));
         a = ($urandom & 32'hFFFF_F000) | (32'h200 + 32'($urandom_range(255)));
         badA = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                (sz == 2'b10 && a[1:0] != 2'b00);
         if (badA)
            mis(0, 1'($urandom_range(1)), a, sz, "rnd_mis");
         else if ($urandom_range(1) == 1)
            st(0, a, $urandom, sz, "rnd_st");
         else begin
            uns = 1'($urandom_range(1));
            ld(0, a, sz, uns, "rnd_ld", refLoad(0, a, sz, uns));
         end
      end
      for (int i = 0; i < 16; i++) begin
         a = 32'h200 + 32'(4 * $urandom_range(63));
         ld(0, a, 2'b10, 0, "rnd_lw", refLoad(0, a, 2'b10, 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
